// File: rtl/treasure_color_pkg.sv
// ============================================================================
// treasure_color_pkg : shared result codes, RGB332 field helpers, FSM states
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package treasure_color_pkg;

   localparam int SCREEN_WIDTH  = 176;
   localparam int SCREEN_HEIGHT = 144;

   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_BLUE = 2'b01;
   localparam logic [1:0] RES_RED  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_DECIDE = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   function automatic logic [2:0] rgb332_r(input logic [7:0] pix);
      return pix[7:5];
   endfunction

   function automatic logic [2:0] rgb332_g(input logic [7:0] pix);
      return pix[4:2];
   endfunction

   function automatic logic [1:0] rgb332_b(input logic [7:0] pix);
      return pix[1:0];
   endfunction

   // Counters stick at full scale instead of wrapping back to a small value.
   function automatic logic [14:0] sat_inc15(input logic [14:0] cnt, input logic hit);
      if (hit && (cnt != 15'h7FFF))
         return cnt + 15'd1;
      return cnt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/treasure_color_classifier_classify.sv
// ============================================================================
// rgb332_color_classify : combinational RGB332 pixel -> {is_red, is_blue}
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rgb332_color_classify
   import treasure_color_pkg::*;
#(
   parameter logic [2:0] RED_MIN   = 3'd5,
   parameter logic [1:0] BLUE_MIN  = 2'd2,
   parameter logic [2:0] OTHER_MAX = 3'd2
) (
   input  logic [7:0] i_pixel,
   output logic       o_is_red,
   output logic       o_is_blue
);

   logic [2:0] w_r;
   logic [2:0] w_g;
   logic [1:0] w_b;

   assign w_r = rgb332_r(i_pixel);
   assign w_g = rgb332_g(i_pixel);
   assign w_b = rgb332_b(i_pixel);

   assign o_is_red  = (w_r >= RED_MIN) && (w_g <= OTHER_MAX) && (w_b == 2'd0);
   assign o_is_blue = (w_b >= BLUE_MIN) && (w_r <= OTHER_MAX) && (w_g <= OTHER_MAX);

endmodule

`default_nettype wire

// File: rtl/treasure_color_classifier.sv
// ============================================================================
// treasure_color_classifier : per-frame red/blue pixel count with debounced result
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module treasure_color_classifier
   import treasure_color_pkg::*;
#(
   parameter int         WIDTH         = SCREEN_WIDTH,
   parameter int         HEIGHT        = SCREEN_HEIGHT,
   parameter logic [2:0] RED_MIN       = 3'd5,
   parameter logic [1:0] BLUE_MIN      = 2'd2,
   parameter logic [2:0] OTHER_MAX     = 3'd2,
   parameter int         COUNT_THRESH  = 2000,
   parameter int         STABLE_FRAMES = 3
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [7:0]  PIXEL_IN,
   input  logic [9:0]  VGA_PIXEL_X,
   input  logic [9:0]  VGA_PIXEL_Y,
   output logic [1:0]  RESULT,
   output logic        RESULT_VALID,
   output logic [14:0] RED_COUNT,
   output logic [14:0] BLUE_COUNT
);

   localparam int                  c_stab_w = $clog2(STABLE_FRAMES + 1);
   localparam logic [9:0]          c_width  = 10'(WIDTH);
   localparam logic [9:0]          c_height = 10'(HEIGHT);
   localparam logic [9:0]          c_last_x = 10'(WIDTH - 1);
   localparam logic [9:0]          c_last_y = 10'(HEIGHT - 1);
   localparam logic [14:0]         c_thresh = 15'(COUNT_THRESH);
   localparam logic [c_stab_w-1:0] c_stable = c_stab_w'(STABLE_FRAMES);

   // PIXEL_IN is the registered M9K read of the previous cycle's X/Y
   logic [9:0]          r_x_d;
   logic [9:0]          r_y_d;
   logic                r_inwin_d;
   state_t              r_state;
   logic [14:0]         r_acc_red;
   logic [14:0]         r_acc_blue;
   logic [1:0]          r_frame_dec;
   logic [1:0]          r_cand;
   logic [c_stab_w-1:0] r_stable;

   logic                w_inwin;
   logic                w_is_red;
   logic                w_is_blue;
   logic                w_red_hit;
   logic                w_blue_hit;
   logic                w_first;
   logic                w_last;
   logic [1:0]          w_frame_dec;
   logic [c_stab_w-1:0] w_stable_next;

   rgb332_color_classify #(
      .RED_MIN   (RED_MIN),
      .BLUE_MIN  (BLUE_MIN),
      .OTHER_MAX (OTHER_MAX)
   ) u_classify (
      .i_pixel   (PIXEL_IN),
      .o_is_red  (w_is_red),
      .o_is_blue (w_is_blue)
   );

   assign w_inwin    = (VGA_PIXEL_X < c_width) && (VGA_PIXEL_Y < c_height);
   assign w_red_hit  = r_inwin_d & w_is_red;
   assign w_blue_hit = r_inwin_d & w_is_blue;
   assign w_first    = (r_x_d == 10'd0) && (r_y_d == 10'd0);
   assign w_last     = (r_x_d == c_last_x) && (r_y_d == c_last_y);

   always_comb begin
      w_frame_dec = RES_NONE;
      if ((r_acc_red > r_acc_blue) && (r_acc_red >= c_thresh))
         w_frame_dec = RES_RED;
      else if ((r_acc_blue > r_acc_red) && (r_acc_blue >= c_thresh))
         w_frame_dec = RES_BLUE;
   end

   // A repeated decision walks the stable count up to its ceiling; a new one restarts it.
   always_comb begin
      w_stable_next = c_stab_w'(1);
      if (r_frame_dec == r_cand)
         w_stable_next = (r_stable >= c_stable) ? c_stable : r_stable + c_stab_w'(1);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_x_d        <= 10'd0;
         r_y_d        <= 10'd0;
         r_inwin_d    <= 1'b0;
         r_state      <= ST_IDLE;
         r_acc_red    <= 15'd0;
         r_acc_blue   <= 15'd0;
         r_frame_dec  <= RES_NONE;
         r_cand       <= RES_NONE;
         r_stable     <= '0;
         RESULT       <= RES_NONE;
         RESULT_VALID <= 1'b0;
         RED_COUNT    <= 15'd0;
         BLUE_COUNT   <= 15'd0;
      end else begin
         r_x_d        <= VGA_PIXEL_X;
         r_y_d        <= VGA_PIXEL_Y;
         r_inwin_d    <= w_inwin;
         RESULT_VALID <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_first) begin
                  r_acc_red  <= {14'd0, w_red_hit};
                  r_acc_blue <= {14'd0, w_blue_hit};
                  r_state    <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               // Origin seen again means the frame was cut short: start over.
               if (w_first) begin
                  r_acc_red  <= {14'd0, w_red_hit};
                  r_acc_blue <= {14'd0, w_blue_hit};
               end else begin
                  r_acc_red  <= sat_inc15(r_acc_red, w_red_hit);
                  r_acc_blue <= sat_inc15(r_acc_blue, w_blue_hit);
                  if (w_last)
                     r_state <= ST_DECIDE;
               end
            end
            ST_DECIDE: begin
               RED_COUNT   <= r_acc_red;
               BLUE_COUNT  <= r_acc_blue;
               r_frame_dec <= w_frame_dec;
               r_state     <= ST_COMMIT;
            end
            ST_COMMIT: begin
               r_cand       <= r_frame_dec;
               r_stable     <= w_stable_next;
               if (w_stable_next == c_stable)
                  RESULT <= r_frame_dec;
               RESULT_VALID <= 1'b1;
               r_state      <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
